// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of a single synchronous-read memory.
// Each access takes IDLE -> ACCESS -> DONE, so one access completes every three cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] adr0,
  input  logic [ADDR_WIDTH-1:0] adr1,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic [DATA_WIDTH-1:0] wd1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] madr,
  output logic [DATA_WIDTH-1:0] mwd,
  output logic                  mwe,
  input  logic [DATA_WIDTH-1:0] mrd,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;   // 1 = port 1 owned the previous access
  logic [ADDR_WIDTH-1:0] madr_q, madr_d;
  logic [DATA_WIDTH-1:0] mwd_q, mwd_d;
  logic                  mwe_q, mwe_d;
  logic [1:0]            ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  win1;

  // Pick the winner among the current requests; only used in IDLE.
  always_comb begin
    win1 = req1;
    if (req0 && req1) begin
      win1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    madr_d  = madr_q;
    mwd_d   = mwd_q;
    mwe_d   = mwe_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StAccess;
          grant_d = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          madr_d  = win1 ? adr1 : adr0;
          mwd_d   = win1 ? wd1 : wd0;
          mwe_d   = win1 ? we1 : we0;
          busy_d  = 1'b1;
        end
      end
      StAccess: begin
        state_d = StDone;
        mwe_d   = 1'b0;
        ack_d   = grant_q;
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
        ack_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
        mwe_d   = 1'b0;
        ack_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts any access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      madr_q  <= '0;
      mwd_q   <= '0;
      mwe_q   <= 1'b0;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      madr_q  <= madr_d;
      mwd_q   <= mwd_d;
      mwe_q   <= mwe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0  = ack_q[0];
  assign ack1  = ack_q[1];
  assign grant = grant_q;
  assign madr  = madr_q;
  assign mwd   = mwd_q;
  assign mwe   = mwe_q;
  assign busy  = busy_q;
  // Synchronous-read data lands in DONE; only meaningful while an ack is high.
  assign rdata = mrd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share stimulus;
// each has its own memory and transaction-level reference model feeding a scoreboard.
module tb_mem_arbiter;

  typedef struct {
    int          cyc;   // negedge index at which the ack is expected
    int          port;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] adr0, adr1, wd0, wd1;

  logic [1:0]  ack0_s, ack1_s, mwe_s, busy_s;
  logic [1:0]  grant_s [2];
  logic [31:0] rdata_s [2];
  logic [31:0] madr_s  [2];
  logic [31:0] mwd_s   [2];
  logic [31:0] mrd_s   [2];
  logic [31:0] mem_m   [2][64];
  logic [31:0] ref_mem [2][64];

  exp_t q [2][$];
  int   free_at [2];
  int   last_p  [2];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   skip_mon = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .ack0(ack0_s[0]), .ack1(ack1_s[0]), .rdata(rdata_s[0]),
    .madr(madr_s[0]), .mwd(mwd_s[0]), .mwe(mwe_s[0]), .mrd(mrd_s[0]),
    .grant(grant_s[0]), .busy(busy_s[0])
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .ack0(ack0_s[1]), .ack1(ack1_s[1]), .rdata(rdata_s[1]),
    .madr(madr_s[1]), .mwd(mwd_s[1]), .mwe(mwe_s[1]), .mrd(mrd_s[1]),
    .grant(grant_s[1]), .busy(busy_s[1])
  );

  // Synchronous-read memories, one per arbiter instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mwe_s[k]) mem_m[k][madr_s[k][7:2]] <= mwd_s[k];
      mrd_s[k] <= mem_m[k][madr_s[k][7:2]];
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d at cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs and advance the reference models.
  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1,
                       input logic [31:0] d1);
    exp_t        e;
    logic [31:0] a;
    req0 = r0; we0 = w0; adr0 = a0; wd0 = d0;
    req1 = r1; we1 = w1; adr1 = a1; wd1 = d1;
    for (int k = 0; k < 2; k++) begin
      if (cyc >= free_at[k] && (r0 || r1)) begin
        if (r0 && r1) e.port = (k == 1) ? 0 : ((last_p[k] == 1) ? 0 : 1);
        else          e.port = r0 ? 0 : 1;
        e.cyc = cyc + 2;
        e.we  = (e.port == 0) ? w0 : w1;
        e.adr = (e.port == 0) ? a0 : a1;
        e.wd  = (e.port == 0) ? d0 : d1;
        a     = e.adr;
        e.data = ref_mem[k][a[7:2]];
        if (e.we) ref_mem[k][a[7:2]] = e.wd;
        q[k].push_back(e);
        last_p[k]  = e.port;
        free_at[k] = cyc + 3;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    end
  endtask

  // Scoreboard monitor: checks the access phase, the ack phase and quiet cycles.
  always @(negedge clk) begin
    if (rst_n && !skip_mon) begin
      for (int k = 0; k < 2; k++) begin
        logic [1:0] g;
        logic [1:0] ack;
        ack = {ack1_s[k], ack0_s[k]};
        if (q[k].size() != 0 && q[k][0].cyc == cyc + 1) begin
          g = (q[k][0].port == 1) ? 2'b10 : 2'b01;
          chk("access_madr", k, madr_s[k], q[k][0].adr);
          chk("access_mwd", k, mwd_s[k], q[k][0].wd);
          chk("access_mwe", k, 32'(mwe_s[k]), 32'(q[k][0].we));
          chk("access_grant", k, 32'(grant_s[k]), 32'(g));
          chk("access_ack", k, 32'(ack), 32'h0);
          chk("access_busy", k, 32'(busy_s[k]), 32'h1);
        end else if (q[k].size() != 0 && q[k][0].cyc == cyc) begin
          g = (q[k][0].port == 1) ? 2'b10 : 2'b01;
          chk("done_ack", k, 32'(ack), 32'(g));
          chk("done_grant", k, 32'(grant_s[k]), 32'(g));
          chk("done_mwe", k, 32'(mwe_s[k]), 32'h0);
          chk("done_madr", k, madr_s[k], q[k][0].adr);
          if (!q[k][0].we) chk("done_rdata", k, rdata_s[k], q[k][0].data);
          void'(q[k].pop_front());
        end else begin
          chk("idle_ack", k, 32'(ack), 32'h0);
          chk("idle_mwe", k, 32'(mwe_s[k]), 32'h0);
          chk("idle_grant", k, 32'(grant_s[k]), 32'h0);
          chk("idle_busy", k, 32'(busy_s[k]), 32'h0);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
    free_at[0] = 0; free_at[1] = 0;
    last_p[0] = 1;  last_p[1] = 1;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      if (i == 16) v = 32'hDEADBEEF;
      mem_m[0][i] = v; mem_m[1][i] = v;
      ref_mem[0][i] = v; ref_mem[1][i] = v;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ack", k, 32'({ack1_s[k], ack0_s[k]}), 32'h0);
      chk("reset_mwe", k, 32'(mwe_s[k]), 32'h0);
      chk("reset_madr", k, madr_s[k], 32'h0);
      chk("reset_mwd", k, mwd_s[k], 32'h0);
      chk("reset_grant", k, 32'(grant_s[k]), 32'h0);
      chk("reset_busy", k, 32'(busy_s[k]), 32'h0);
    end

    // Tie in the first IDLE cycle after reset, both held for 12 cycles.
    rst_n = 1'b1;
    drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h80, 32'h0);
    repeat (11) begin
      @(negedge clk);
      drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h80, 32'h0);
    end
    idle(3);

    // Single read of the preloaded word.
    @(negedge clk);
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(3);

    // Port 1 writes, then port 0 reads back.
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h80, 32'h12345678);
    idle(3);
    @(negedge clk);
    drive(1, 0, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(3);

    repeat (300) begin
      @(negedge clk);
      drive($urandom_range(0, 4) < 3, 1'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom,
            $urandom_range(0, 4) < 3, 1'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom);
    end
    idle(4);

    // Reset taken while a write is in ACCESS: abort, no ack.
    @(negedge clk);
    skip_mon = 1'b1;
    req0 = 0; req1 = 1; we1 = 1; adr1 = 32'hC0; wd1 = 32'hCAFEF00D;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_pre_mwe", k, 32'(mwe_s[k]), 32'h1);
      chk("rst_pre_grant", k, 32'(grant_s[k]), 32'h2);
    end
    req1 = 0; we1 = 0;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_mid_mwe", k, 32'(mwe_s[k]), 32'h0);
      chk("rst_mid_grant", k, 32'(grant_s[k]), 32'h0);
      chk("rst_mid_busy", k, 32'(busy_s[k]), 32'h0);
      chk("rst_mid_ack", k, 32'({ack1_s[k], ack0_s[k]}), 32'h0);
      // mwe was high on the reset edge, so the write still landed.
      ref_mem[k][48] = 32'hCAFEF00D;
      free_at[k] = cyc;
      last_p[k]  = 1;
    end
    rst_n = 1'b1;
    skip_mon = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_post_ack", k, 32'({ack1_s[k], ack0_s[k]}), 32'h0);
    end
    drive(1, 0, 32'hC0, 32'h0, 1, 0, 32'h40, 32'h0);

    repeat (100) begin
      @(negedge clk);
      drive($urandom_range(0, 4) < 3, 1'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom,
            $urandom_range(0, 4) < 3, 1'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom);
    end
    idle(5);
    for (int k = 0; k < 2; k++) begin
      chk("queue_drained", k, 32'(q[k].size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
